// File: rtl/pipo_piso_sipo_pkg.sv
// Shared definitions for the serial link blocks (piso transmitter, sipo receiver).
package pipo_piso_sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int LINK_WIDTH = 4;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless back-to-back frames.
// Optional even-parity trailer bit enabled by defining PIPO_PISO_SIPO_PARITY_EN.
//
// state | meaning
// IDLE  | no frame in flight, load_ready=1, outputs quiet
// SHIFT | one bit per cycle on s_out, load_ready=1 only on the final bit
module piso_tx
    import pipo_piso_sipo_pkg::*;
#(
    parameter int WIDTH     = LINK_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] p_in,
    output logic             load_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
`ifdef PIPO_PISO_SIPO_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_out_q, s_out_d;
    logic             s_valid_q, s_valid_d;
    logic             frame_done_q, frame_done_d;
`ifdef PIPO_PISO_SIPO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shreg_sh;
    logic [CW-1:0]    cnt_inc;

    assign load_ready = (state_q == IDLE) || (cnt_q == LAST);
    assign accept     = load_valid && load_ready;

    // The shift register holds the word with the bit on s_out at the leading end.
    assign first_bit = MSB_FIRST ? p_in[WIDTH-1] : p_in[0];
    assign shreg_sh  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    assign next_bit  = MSB_FIRST ? shreg_sh[WIDTH-1] : shreg_sh[0];
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        s_out_d      = 1'b0;
        s_valid_d    = 1'b0;
        frame_done_d = 1'b0;
`ifdef PIPO_PISO_SIPO_PARITY_EN
        parity_d     = parity_q;
`endif
        if (accept) begin
            state_d   = SHIFT;
            shreg_d   = p_in;
            cnt_d     = '0;
            s_out_d   = first_bit;
            s_valid_d = 1'b1;
`ifdef PIPO_PISO_SIPO_PARITY_EN
            parity_d  = ^p_in;
`endif
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                shreg_d      = shreg_sh;
                cnt_d        = cnt_inc;
                s_valid_d    = 1'b1;
                s_out_d      = next_bit;
                frame_done_d = (cnt_inc == LAST);
`ifdef PIPO_PISO_SIPO_PARITY_EN
                if (cnt_q == DATA_LAST) begin
                    s_out_d = parity_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            s_out_q      <= 1'b0;
            s_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PIPO_PISO_SIPO_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            s_out_q      <= s_out_d;
            s_valid_q    <= s_valid_d;
            frame_done_q <= frame_done_d;
`ifdef PIPO_PISO_SIPO_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign s_out      = s_out_q;
    assign s_valid    = s_valid_q;
    assign frame_done = frame_done_q;

endmodule
